// File: rtl/lyra2_axi_pkg.sv
// Shared definitions for the Lyra2 output-side AXI4-Lite reader: register map,
// response codes, hash type and FSM state encodings.
package lyra2_axi_pkg;

    localparam int NWORDS = 8;

    localparam logic [7:0] REG_STATUS    = 8'h00;
    localparam logic [7:0] REG_CNT       = 8'h08;
    localparam logic [7:0] REG_DATA_BASE = 8'h20;
    localparam logic [7:0] REG_DATA_LAST = 8'h3C;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [255:0] hash_t;

    localparam logic [1:0] B_EMPTY = 2'd0;
    localparam logic [1:0] B_LOAD  = 2'd1;
    localparam logic [1:0] B_FULL  = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    // DATA_0..DATA_7 live at 0x20..0x3C, word aligned
    function automatic logic is_data_addr(input logic [7:0] addr);
        return (addr[7:5] == 3'b001) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/lyra2_hash_buffer.sv
// Holding buffer for one 256-bit hash: pops the output FIFO (1-cycle read
// latency) whenever the buffer is empty and releases it on pop_req.
module lyra2_hash_buffer
    import lyra2_axi_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  pop_req,
    input  hash_t fifo_dout,
    input  logic  fifo_empty,
    output logic  fifo_rd_en,
    output logic  buf_valid,
    output hash_t hash
);

    logic [1:0] r_state;
    hash_t      r_hash;
    logic       r_armed;
    logic       w_fetch;

    // r_armed keeps the pop request quiet while reset is asserted
    assign w_fetch    = r_armed && (r_state == B_EMPTY) && !fifo_empty;
    assign fifo_rd_en = w_fetch;
    assign buf_valid  = (r_state == B_FULL);
    assign hash       = r_hash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= B_EMPTY;
            r_hash  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                B_EMPTY: if (w_fetch) r_state <= B_LOAD;
                B_LOAD: begin
                    r_hash  <= fifo_dout;
                    r_state <= B_FULL;
                end
                B_FULL:  if (pop_req) r_state <= B_EMPTY;
                default: r_state <= B_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/lyra2_out_axi_reader.sv
// AXI4-Lite read-only slave exposing the prefetched Lyra2 hash as DATA_0..7
// plus STATUS. Define LYRA2_RD_CNT_EN to add the consumed-hash counter at 0x08.
module lyra2_out_axi_reader
    import lyra2_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int HASH_WIDTH     = 256
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [HASH_WIDTH-1:0]     fifo_dout,
    input  logic                      fifo_empty,
    input  logic                      fifo_almost_full,
    output logic                      fifo_rd_en
);

    logic [0:0]                r_state;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;

    logic [7:0]                w_addr;
    logic                      w_ar_hs;
    logic                      w_pop;
    logic                      w_buf_valid;
    hash_t                     w_hash;
    logic [31:0]               w_words [NWORDS];
    logic [AXI_DATA_WIDTH-1:0] w_rdata;
    logic [1:0]                w_rresp;

    assign w_addr  = s_axi_araddr[7:0];
    assign w_ar_hs = s_axi_arvalid && (r_state == R_IDLE);
    // Only a successful DATA_7 read releases the buffer
    assign w_pop   = w_ar_hs && (w_addr == REG_DATA_LAST) && w_buf_valid;

    lyra2_hash_buffer u_buf (
        .clk        (s_axi_aclk),
        .rst_n      (s_axi_aresetn),
        .pop_req    (w_pop),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .buf_valid  (w_buf_valid),
        .hash       (w_hash)
    );

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
            assign w_words[gi] = w_hash[32*gi +: 32];
        end
    endgenerate

`ifdef LYRA2_RD_CNT_EN
    logic [31:0] r_cnt;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end
`endif

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_SLVERR;
        if (w_addr == REG_STATUS) begin
            w_rdata = {{(AXI_DATA_WIDTH-3){1'b0}}, fifo_empty, fifo_almost_full, w_buf_valid};
            w_rresp = RESP_OKAY;
        end
`ifdef LYRA2_RD_CNT_EN
        else if (w_addr == REG_CNT) begin
            w_rdata = r_cnt;
            w_rresp = RESP_OKAY;
        end
`endif
        else if (is_data_addr(w_addr) && w_buf_valid) begin
            w_rdata = w_words[w_addr[4:2]];
            w_rresp = RESP_OKAY;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= R_IDLE;
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rdata <= w_rdata;
                        r_rresp <= w_rresp;
                        r_state <= R_RESP;
                    end
                end
                R_RESP:  if (s_axi_rready) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s_axi_arready = (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_RESP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

endmodule
